ram_rd_arb: RTL

Round-robin read arbiter that shares the single read port of `ram_rtl` (enb/addrb/doutb) among `NUM_REQ` independent requesters. Each requester issues addresses through a valid/ready handshake. The block drives the RAM read port from registers and tracks the owner of every in-flight read with a tag pipeline. It returns the registered read data to the owner with a one-hot valid. It sits between the RAM instance and its consumers (e.g. FIFO read logic, table lookups); the RAM write port is untouched.

---
 rtl/ram_ctrl_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/ram_rd_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants and helpers for the RAM controller blocks.
package ram_ctrl_pkg;

  // Read latency of the RAM for each read mode.
  localparam int unsigned RD_LAT_STD = 1;
  localparam int unsigned RD_LAT_REG = 2;

  // Upper bound on requesters; sizes the one-hot helper.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  // Ceiling log2, never less than 1 so a 2-entry index still has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // One-hot decode of an index, MAX_REQ wide; callers slice to their width.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  // First requester found walking from last+1 (mod N) wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (en) begin
      for (int unsigned off = 1; off <= N; off++) begin
        cand = IW'((32'(last) + off) % N);
        if (!found && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/ram_rd_arb.sv
// Round-robin sharing of the RAM read port among NUM_REQ requesters.
// Owner of each in-flight read rides a tag shift register to the response.
module ram_rd_arb
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = RD_LAT_STD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_enb,
  output logic [ADDR_WIDTH-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0]         ram_doutb
);

  localparam int unsigned IW = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   grant;
  logic                   arb_en_eff;
  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic [MAX_REQ-1:0]     out_oh;

  logic [IW-1:0]          last_q, last_d;
  logic                   enb_q, enb_d;
  logic [ADDR_WIDTH-1:0]  addrb_q, addrb_d;
  logic [RD_LAT:0]        tag_vld_q, tag_vld_d;
  logic [RD_LAT:0][IW-1:0] tag_idx_q, tag_idx_d;
  logic [NUM_REQ-1:0]     rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  // No grants while reset is asserted, so req_rdy reads 0 during reset.
  assign arb_en_eff = arb_en & ~rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req),
    .en      (arb_en_eff),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant = |gnt;

  // Address of the granted requester (AND-OR mux over one-hot grant).
  always_comb begin
    issue_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) issue_addr = issue_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Next state: pointer, issue registers, tag shift and response stage.
  always_comb begin
    last_d     = last_q;
    enb_d      = grant;
    addrb_d    = addrb_q;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (grant) begin
      last_d  = gnt_idx;
      addrb_d = issue_addr;
    end
    // Entry k describes the read whose RAM data is due k cycles after issue.
    tag_vld_d = {tag_vld_q[RD_LAT-1:0], grant};
    tag_idx_d = {tag_idx_q[RD_LAT-1:0], gnt_idx};
    out_oh    = onehot(MAX_IDX_W'(tag_idx_q[RD_LAT]));
    if (tag_vld_q[RD_LAT]) begin
      rsp_vld_d  = out_oh[NUM_REQ-1:0];
      rsp_data_d = ram_doutb;
    end
  end

  // State registers with synchronous reset; reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= IW'(NUM_REQ - 1);
      enb_q      <= 1'b0;
      addrb_q    <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      last_q     <= last_d;
      enb_q      <= enb_d;
      addrb_q    <= addrb_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req_rdy   = gnt;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_data  = rsp_data_q;
  assign ram_enb   = enb_q;
  assign ram_addrb = addrb_q;

endmodule
